// File: rtl/input_debounce_pkg.sv
// Package for input_debounce: pulls in the shared defs and builds the
// state enum from their encodings.
package input_debounce_pkg;
  `include "input_debounce_defs.vh"

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT
  } state_e;
endpackage

// File: rtl/input_debounce_defs.vh
// Shared constants for the input debouncer: state encodings and the
// default stable-cycle threshold.
localparam logic ST_IDLE  = 1'b0;
localparam logic ST_COUNT = 1'b1;
localparam logic [15:0] DEBOUNCE_THRESH_DEF = 16'd1000;

// File: rtl/sync_chain.sv
// Generic multi-flop level synchroniser for one asynchronous input bit.
// Reusable for any single-bit CDC level signal.
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift register: d enters at bit 0, q leaves from the top bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronising glitch filter for one raw input pin. Define
// INPUT_DEBOUNCE_EDGE_EN to get registered rise/fall pulses on dout.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             din,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             dout,
  output logic             busy,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic             din_s;
  logic             mismatch_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (din),
    .q    (din_s)
  );

  assign mismatch_s = (din_s != dout_q);

  // State, counter and output level registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic; >= compare means a lowered threshold takes effect at once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en && mismatch_s) begin
          if (cfg_thresh == '0) begin
            dout_d = din_s;
          end else begin
            state_d = S_COUNT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (!mismatch_s || !en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= cfg_thresh) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dout_d  = din_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = dout_q;
  assign busy = (state_q == S_COUNT);

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses register on the same edge that updates dout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed, table-driven bench for input_debounce (defaults: 2 sync stages,
// 16-bit counter, reset value 0). Pulse expectations follow INPUT_DEBOUNCE_EDGE_EN.
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  typedef struct {
    logic        rstn;
    logic        en;
    logic        din;
    logic [15:0] thr;
    logic        dout;
    logic        busy;
    logic        rise;
    logic        fall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        din;
  logic [15:0] cfg_thresh;
  logic        dout;
  logic        busy;
  logic        rise_pulse;
  logic        fall_pulse;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  input_debounce dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .din        (din),
    .cfg_thresh (cfg_thresh),
    .dout       (dout),
    .busy       (busy),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic e_dout, input logic e_busy,
                         input logic e_rise, input logic e_fall);
    chk({nm, " dout"}, dout, e_dout);
    chk({nm, " busy"}, busy, e_busy);
    chk({nm, " rise"}, rise_pulse, e_rise & EDGE);
    chk({nm, " fall"}, fall_pulse, e_fall & EDGE);
  endtask

  function automatic void add(input logic r, input logic e, input logic d, input logic [15:0] t,
                              input logic xd, input logic xb, input logic xr, input logic xf);
    vec_t v;
    v.rstn = r; v.en = e; v.din = d; v.thr = t;
    v.dout = xd; v.busy = xb; v.rise = xr; v.fall = xf;
    vecs.push_back(v);
  endfunction

  initial begin
    rstn = 1'b0; en = 1'b1; din = 1'b0; cfg_thresh = 16'd4;

    // reset held with din toggling
    add(1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    // clean step, threshold 4: busy from edge 3, dout at edge 7
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    // 3-cycle low glitch is rejected
    add(1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    // zero threshold: flips at edge 3, busy never set
    add(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    #1;
    foreach (vecs[i]) begin
      rstn       = vecs[i].rstn;
      en         = vecs[i].en;
      din        = vecs[i].din;
      cfg_thresh = vecs[i].thr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].busy, vecs[i].rise, vecs[i].fall);
    end

    // enable abort after 5 counting cycles, then full 11-cycle recount
    cfg_thresh = 16'd10;
    din = 1'b1;
    tick(); tick(); tick();
    chk_all("abort start", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk_all("abort cnt5", 1'b0, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    chk_all("abort en low", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_all("abort hold", 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("recount%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("recount flip", 1'b1, 1'b0, 1'b1, 1'b0);

    // threshold lowered from 100 to 2 at cnt 50
    cfg_thresh = 16'd100;
    din = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 49; i++) tick();
    chk_all("lower cnt50", 1'b1, 1'b1, 1'b0, 1'b0);
    cfg_thresh = 16'd2;
    tick();
    chk_all("lower flip", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("lower after", 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-count clears busy without a clock edge
    cfg_thresh = 16'd4;
    din = 1'b1;
    tick(); tick(); tick(); tick();
    chk_all("rst precount", 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_all("rst async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    chk_all("rst refill", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Conditions raw asynchronous level inputs (buttons, external pins, GPIO) before they reach the posedge/negedge/both-edge detectors.
- Synchronises the input into clk, then rejects glitches shorter than a programmable cycle count.
- Emits a clean, stable level that downstream edge detection can consume directly.
- One instance per input pin.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal 2..4).
- CNT_W, 16, width of the debounce counter and of cfg_thresh.
- RST_VAL, 1'b0, reset value of the synchroniser flops and of dout.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous assert, active-low.
- en  input  1  filter enable; low freezes dout and clears the counter.
- din  input  1  raw asynchronous input level.
- cfg_thresh  input  CNT_W  stable-cycle threshold; quasi-static register-driven value.
- dout  output  1  debounced, synchronised level (registered).
- busy  output  1  high while a candidate change is being counted (registered).
- rise_pulse  output  1  one-cycle pulse on dout 0->1 (optional feature).
- fall_pulse  output  1  one-cycle pulse on dout 1->0 (optional feature).

Behaviour:
- Reset: the interface uses reset rstn, asynchronous, active-low, and clock clk.
  - Synchroniser flops = RST_VAL, dout = RST_VAL.
  - cnt = 0, state = IDLE, busy = 0, rise_pulse/fall_pulse = 0.
- Synchroniser: din passes through SYNC_STAGES flops to give din_s. No other logic touches din.
- mismatch = (din_s != dout).
- State machine, two states:
  - IDLE: cnt = 0, busy = 0. If en && mismatch, go to COUNT with cnt = 1. If cfg_thresh == 0 at that point, dout flips on this same edge instead and the state stays IDLE.
  - COUNT: busy = 1.
    - If !mismatch or !en: return to IDLE, cnt = 0, dout unchanged. This is the glitch-rejected case.
    - Else if cnt >= cfg_thresh: dout <= din_s, cnt = 0, go to IDLE.
    - Else cnt <= cnt + 1.
- Flip condition: dout flips on the edge that completes cfg_thresh+1 consecutive mismatch cycles.
- Latency from a clean din step to dout = SYNC_STAGES + cfg_thresh + 1 clk edges.
- Counter compare uses >=:
  - cnt never wraps.
  - If cfg_thresh is lowered below cnt mid-count, dout flips on the next edge.
- Pulses shorter than cfg_thresh+1 cycles (as seen at din_s) never reach dout.
- en deassert mid-count aborts the count and dout holds. din_s keeps sampling while en is low.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous). The synchroniser refills after rstn release.

Optional Feature:
- Macro: INPUT_DEBOUNCE_EDGE_EN.
- Defined:
  - rise_pulse/fall_pulse are registered.
  - Each is high for exactly the one cycle in which dout first shows its new value, i.e. the same edge that updates dout asserts the pulse.
- Undefined: both ports are tied 0 and no pulse flops are generated.

Decomposition:
- Shared include file input_debounce_defs.vh holds:
  - state encodings ST_IDLE = 1'b0, ST_COUNT = 1'b1;
  - the default threshold constant DEBOUNCE_THRESH_DEF = 16'd1000.
- One sub-module, sync_chain:
  - parameters SYNC_STAGES and RST_VAL;
  - ports clk, rstn, d, q;
  - reusable for other CDC inputs.

Test Plan:
- Reset: hold rstn = 0 with din toggling -> dout = 0, busy = 0, pulses = 0 throughout. After release, first change is observed no earlier than SYNC_STAGES edges later.
- Clean step: cfg_thresh = 4, en = 1, din 0->1 and held -> busy rises at edge 3, dout = 1 at edge 7 (2+4+1), rise_pulse high one cycle at edge 7 (macro on).
- Glitch rejection: cfg_thresh = 4, din high for 3 cycles then low -> dout stays 0, busy drops, cnt returns to 0, no pulse.
- Zero threshold: cfg_thresh = 0, din 1->0 -> dout = 0 at edge 3, fall_pulse one cycle, busy never asserts.
- Enable abort: cfg_thresh = 10, din step, en dropped after 5 counting cycles -> dout unchanged, busy = 0. en re-asserted with din still high -> full 11 counting cycles required before dout flips.
- Threshold lowered mid-count: cfg_thresh 100 -> 2 while cnt = 50 -> dout flips on the next edge. Then with the macro undefined, confirm rise_pulse/fall_pulse are constant 0.
